// File: rtl/cla_pipe_addsub.sv
// cla_pipe_addsub
//   Pipelined carry-lookahead adder/subtractor with a valid/ready handshake,
//   used as the shared ALU adder. The WIDTH-bit operands are cut into STAGES
//   equal segments. Stage k adds segment k with 4-bit generate/propagate groups
//   and group lookahead. Its carry-in is the carry registered by stage k-1.
//   One operation can issue every cycle. The latency is exactly STAGES cycles.
//
// Parameters
//   WIDTH   operand/result width, a multiple of 4*STAGES
//   STAGES  pipeline depth / segment count (1, 2, 4 or 8)
//   TAG_W   sideband tag width
//
// Ports
//   clk, rst           clock (rising edge), asynchronous active-high reset
//   in_valid/in_ready  input handshake; in_ready depends only on out_ready
//                      and internal state
//   a, b, cin, op      operands, carry/borrow-in and opcode
//                      (00 ADD, 01 ADC, 10 SUB, 11 SBC)
//   in_tag             sideband tag, returned unchanged with the result
//   out_valid/out_ready output handshake
//   sum, cout, ovf,    result and flags; they hold while the output is stalled
//   zero, out_tag      and while out_valid is low
module cla_pipe_addsub #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2,
  parameter int TAG_W  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic [1:0]       op,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic [TAG_W-1:0] out_tag
);

  localparam int SEG  = WIDTH / STAGES;
  localparam int GRP  = SEG / 4;
  localparam int LAST = STAGES - 1;

  // Adds one segment using 4-bit groups. Each carry inside a group is the
  // full sum of products of that group's g/p bits and the group carry-in.
  // The group carry-out (G | P&cin) becomes the next group's carry-in.
  // Return value: {carry into MSB, carry out, sum}.
  function automatic logic [SEG+1:0] cla_seg(input logic [SEG-1:0] x,
                                             input logic [SEG-1:0] y,
                                             input logic           ci);
    logic [SEG:0] c;
    logic [3:0]   g;
    logic [3:0]   p;
    logic         pr;
    logic         cj;
    c    = '0;
    c[0] = ci;
    for (int grp = 0; grp < GRP; grp++) begin
      g = x[grp*4 +: 4] & y[grp*4 +: 4];
      p = x[grp*4 +: 4] ^ y[grp*4 +: 4];
      for (int j = 1; j <= 4; j++) begin
        cj = g[j-1];
        pr = p[j-1];
        for (int i = j - 2; i >= 0; i--) begin
          cj = cj | (pr & g[i]);
          pr = pr & p[i];
        end
        c[grp*4 + j] = cj | (pr & c[grp*4]);
      end
    end
    return {c[SEG-1], c[SEG], x ^ y ^ c[SEG-1:0]};
  endfunction

  logic             adv;
  logic [WIDTH-1:0] b_eff;
  logic             c0;

  // Subtraction adds ~b. The carry-in comes from the opcode for ADD/SUB and
  // from cin for ADC/SBC.
  always_comb begin
    b_eff = op[1] ? ~b : b;
    unique case (op)
      2'b00:   c0 = 1'b0;
      2'b10:   c0 = 1'b1;
      default: c0 = cin;
    endcase
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [WIDTH-1:0] a_in, b_in, s_in, s_nxt;
    logic             c_in, v_in;
    logic [TAG_W-1:0] t_in;
    logic [SEG+1:0]   seg_r;
    logic [WIDTH-1:0] a_p, b_p, sum_p;
    logic             c_p, m_p, z_p, vld_p;
    logic [TAG_W-1:0] tag_p;
    logic             unused_bits;

    if (k == 0) begin : g_head
      assign a_in = a;
      assign b_in = b_eff;
      assign c_in = c0;
      assign s_in = '0;
      assign v_in = in_valid;
      assign t_in = in_tag;
    end else begin : g_tail
      assign a_in = g_stage[k-1].a_p;
      assign b_in = g_stage[k-1].b_p;
      assign c_in = g_stage[k-1].c_p;
      assign s_in = g_stage[k-1].sum_p;
      assign v_in = g_stage[k-1].vld_p;
      assign t_in = g_stage[k-1].tag_p;
    end

    always_comb begin
      seg_r = cla_seg(a_in[k*SEG +: SEG], b_in[k*SEG +: SEG], c_in);
      s_nxt = s_in;
      s_nxt[k*SEG +: SEG] = seg_r[SEG-1:0];
    end

    // Stage k boundary. Operand segments above k skew forward one cycle per
    // stage. Segments already added travel in sum_p until the last stage.
    // Data loads only for valid ops, so the outputs keep their last value
    // when a bubble passes through.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        vld_p <= 1'b0;
        a_p   <= '0;
        b_p   <= '0;
        sum_p <= '0;
        c_p   <= 1'b0;
        m_p   <= 1'b0;
        z_p   <= 1'b0;
        tag_p <= '0;
      end else if (adv) begin
        vld_p <= v_in;
        if (v_in) begin
          a_p   <= a_in;
          b_p   <= b_in;
          sum_p <= s_nxt;
          c_p   <= seg_r[SEG];
          m_p   <= seg_r[SEG+1];
          z_p   <= ~|s_nxt;
          tag_p <= t_in;
        end
      end
    end

    // Collects bits that synthesis trims: operand segments that are already
    // consumed, and the MSB-carry/zero flags of the inner stages.
    assign unused_bits = ^{a_in, b_in, a_p, b_p, m_p, z_p};
  end

  // One global enable: the whole pipe moves unless the output is held.
  assign adv       = !g_stage[LAST].vld_p || out_ready;
  assign in_ready  = adv;
  assign out_valid = g_stage[LAST].vld_p;
  assign sum       = g_stage[LAST].sum_p;
  assign cout      = g_stage[LAST].c_p;
  assign ovf       = g_stage[LAST].m_p ^ g_stage[LAST].c_p;
  assign zero      = g_stage[LAST].z_p;
  assign out_tag   = g_stage[LAST].tag_p;

endmodule
